// File: rtl/key_counter_ctrl.sv
// Key-driven up/down/clear counter with a divided step tick; all outputs registered, key_en takes effect on the next edge.
// No backpressure: every key_en pulse is accepted and overrides any pending step.
module key_counter_ctrl #(
  parameter logic [25:0] CNT_MAX = 26'd49_999_999,
  parameter logic [7:0]  CNT_TOP = 8'd99
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       key_en,
  input  logic [3:0] key_select,
  output logic [7:0] count,
  output logic [1:0] mode,
  output logic       tick,
  output logic       wrap
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    UP    = 2'b01,
    DOWN  = 2'b10,
    CLEAR = 2'b11
  } state_e;

  state_e      state_q, state_d;
  logic [25:0] div_q, div_d;
  logic [7:0]  count_q, count_d;
  logic        tick_q, tick_d;
  logic        wrap_q, wrap_d;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      count_q <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  // A key event always wins over a divider terminal in the same cycle:
  // the divider restarts and no step is taken.
  always_comb begin
    state_d = state_q;
    div_d   = '0;
    count_d = count_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (key_en) begin
      state_d = state_e'(key_select[1:0]);
      if (key_select[1:0] == CLEAR) begin
        count_d = '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        UP, DOWN: begin
          if (div_q == CNT_MAX) begin
            tick_d = 1'b1;
            if (state_q == UP) begin
              if (count_q == CNT_TOP) begin
                count_d = '0;
                wrap_d  = 1'b1;
              end else begin
                count_d = count_q + 8'd1;
              end
            end else begin
              if (count_q == 8'd0) begin
                count_d = CNT_TOP;
                wrap_d  = 1'b1;
              end else begin
                count_d = count_q - 8'd1;
              end
            end
          end else begin
            div_d = div_q + 26'd1;
          end
        end
        CLEAR: begin
          count_d = '0;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign count = count_q;
  assign mode  = state_q;
  assign tick  = tick_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_key_counter_ctrl.sv
// Bench for key_counter_ctrl with a short divider: spec vectors, reset corners, and random keys against a run-length model.
module tb_key_counter_ctrl;

  localparam logic [25:0] CM = 26'd3;
  localparam logic [7:0]  CT = 8'd9;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       key_en;
  logic [3:0] key_select;
  logic [7:0] count;
  logic [1:0] mode;
  logic       tick;
  logic       wrap;

  always #5 sys_clk = ~sys_clk;

  key_counter_ctrl #(.CNT_MAX(CM), .CNT_TOP(CT)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .key_en     (key_en),
    .key_select (key_select),
    .count      (count),
    .mode       (mode),
    .tick       (tick),
    .wrap       (wrap)
  );

  int checks   = 0;
  int failures = 0;

  // Model: cycles elapsed since the last key event decide when a step is due.
  int   m_count, m_mode, m_run;
  logic m_tick, m_wrap;

  typedef struct {
    logic       ken;
    logic [3:0] sel;
    int         ncyc;
    logic [7:0] c;
    logic [1:0] m;
    logic       t;
    logic       w;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic ken, input logic [3:0] sel, input int ncyc,
                             input logic [7:0] c, input logic [1:0] m, input logic t, input logic w);
    vec_t r;
    r.ken = ken; r.sel = sel; r.ncyc = ncyc; r.c = c; r.m = m; r.t = t; r.w = w;
    return r;
  endfunction

  task automatic check(input string name, input logic [7:0] ec, input logic [1:0] em,
                       input logic et, input logic ew);
    checks++;
    if ({count, mode, tick, wrap} !== {ec, em, et, ew}) begin
      failures++;
      $display("FAIL %s: got count=%0d mode=%0d tick=%0b wrap=%0b, want count=%0d mode=%0d tick=%0b wrap=%0b",
               name, count, mode, tick, wrap, ec, em, et, ew);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_mode = 0; m_run = 0; m_tick = 1'b0; m_wrap = 1'b0;
  endtask

  task automatic model_edge(input logic ken, input logic [3:0] sel);
    int top1;
    top1   = int'(CT) + 1;
    m_tick = 1'b0;
    m_wrap = 1'b0;
    if (ken) begin
      m_mode = int'(sel[1:0]);
      m_run  = 0;
      if (m_mode == 3) m_count = 0;
    end else if (m_mode == 1 || m_mode == 2) begin
      m_run++;
      if (m_run % (int'(CM) + 1) == 0) begin
        m_tick = 1'b1;
        if (m_mode == 1) begin
          m_count = (m_count + 1) % top1;
          m_wrap  = (m_count == 0);
        end else begin
          m_count = (m_count + int'(CT)) % top1;
          m_wrap  = (m_count == int'(CT));
        end
      end
    end else if (m_mode == 3) begin
      m_count = 0;
      m_mode  = 0;
    end
  endtask

  task automatic cycle(input logic ken, input logic [3:0] sel, input string tag);
    key_en     = ken;
    key_select = sel;
    @(posedge sys_clk);
    model_edge(ken, sel);
    #1;
    check(tag, 8'(m_count), 2'(m_mode), m_tick, m_wrap);
    key_en     = 1'b0;
    key_select = 4'h0;
  endtask

  initial begin
    sys_rst    = 1'b1;
    key_en     = 1'b0;
    key_select = 4'h0;
    model_reset();

    tbl.push_back(v(1'b1, 4'b0001, 1,  8'd0, 2'd1, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 4'b0000, 4,  8'd1, 2'd1, 1'b1, 1'b0));
    tbl.push_back(v(1'b0, 4'b0000, 4,  8'd2, 2'd1, 1'b1, 1'b0));
    tbl.push_back(v(1'b1, 4'b0010, 1,  8'd2, 2'd2, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 4'b0000, 4,  8'd1, 2'd2, 1'b1, 1'b0));
    tbl.push_back(v(1'b0, 4'b0000, 4,  8'd0, 2'd2, 1'b1, 1'b0));
    tbl.push_back(v(1'b0, 4'b0000, 4,  8'd9, 2'd2, 1'b1, 1'b1));
    tbl.push_back(v(1'b0, 4'b0000, 2,  8'd9, 2'd2, 1'b0, 1'b0));
    tbl.push_back(v(1'b1, 4'b1101, 1,  8'd9, 2'd1, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 4'b0000, 4,  8'd0, 2'd1, 1'b1, 1'b1));
    tbl.push_back(v(1'b0, 4'b0000, 3,  8'd0, 2'd1, 1'b0, 1'b0));
    tbl.push_back(v(1'b1, 4'b0001, 1,  8'd0, 2'd1, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 4'b0000, 3,  8'd0, 2'd1, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 4'b0000, 1,  8'd1, 2'd1, 1'b1, 1'b0));
    tbl.push_back(v(1'b0, 4'b0000, 16, 8'd5, 2'd1, 1'b1, 1'b0));
    tbl.push_back(v(1'b0, 4'b0000, 3,  8'd5, 2'd1, 1'b0, 1'b0));
    tbl.push_back(v(1'b1, 4'b0011, 1,  8'd0, 2'd3, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 4'b0000, 1,  8'd0, 2'd0, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 4'b0000, 5,  8'd0, 2'd0, 1'b0, 1'b0));

    repeat (2) @(posedge sys_clk);
    #1;
    check("reset_state", 8'd0, 2'd0, 1'b0, 1'b0);
    sys_rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].ken, tbl[i].sel, "model_vec");
      for (int k = 1; k < tbl[i].ncyc; k++) cycle(1'b0, 4'h0, "model_vec");
      check($sformatf("vec%0d", i), tbl[i].c, tbl[i].m, tbl[i].t, tbl[i].w);
    end

    // Reset mid-UP at count 7 must clear immediately, without waiting for an edge.
    cycle(1'b1, 4'b0001, "model_up");
    for (int k = 0; k < 28; k++) cycle(1'b0, 4'h0, "model_up");
    check("up_at_7", 8'd7, 2'd1, 1'b1, 1'b0);
    cycle(1'b0, 4'h0, "model_up");
    cycle(1'b0, 4'h0, "model_up");
    #2;
    sys_rst = 1'b1;
    #1;
    check("async_rst", 8'd0, 2'd0, 1'b0, 1'b0);
    model_reset();
    @(posedge sys_clk);
    #1;
    check("rst_held", 8'd0, 2'd0, 1'b0, 1'b0);
    sys_rst = 1'b0;
    for (int k = 0; k < 8; k++) cycle(1'b0, 4'h0, "post_rst_idle");
    check("post_rst_idle_end", 8'd0, 2'd0, 1'b0, 1'b0);
    cycle(1'b1, 4'b0010, "model_first_key");
    check("first_key", 8'd0, 2'd2, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) cycle(1'b0, 4'h0, "model_first_key");
    check("first_down_wrap", 8'd9, 2'd2, 1'b1, 1'b1);

    // Reset mid-CLEAR.
    cycle(1'b1, 4'b0011, "model_clr");
    #2;
    sys_rst = 1'b1;
    #1;
    check("rst_mid_clear", 8'd0, 2'd0, 1'b0, 1'b0);
    model_reset();
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 39) == 0), 4'($urandom_range(0, 15)), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_counter_ctrl.md
KEY_COUNTER_CTRL -- requirements
Module: key_counter_ctrl

Interface
REQ-001 Parameter CNT_MAX, 26'd49_999_999, tick divider terminal value (1 s at 50 MHz).
REQ-002 Parameter CNT_TOP, 8'd99, highest count value before wrap.
REQ-003 sys_clk  input  1  system clock, 50 MHz; single clock domain.
REQ-004 sys_rst  input  1  reset, asynchronous, active-high.
REQ-005 key_en  input  1  one-cycle key event pulse from the key control block.
REQ-006 key_select  input  4  key event code, valid only when key_en=1; bits [1:0] select the mode, bits [3:2] are ignored.
REQ-007 count  output  8  current counter value.
REQ-008 mode  output  2  current FSM state: 00 IDLE, 01 UP, 10 DOWN, 11 CLEAR.
REQ-009 tick  output  1  one-cycle pulse on each count step.
REQ-010 wrap  output  1  one-cycle pulse on each count wrap.

Function
REQ-011 FSM states: IDLE (hold), UP, DOWN, CLEAR.
REQ-012 key_en=1 samples key_select[1:0] and moves to the matching state on the next clock edge, from any state.
REQ-013 key_en=1 with key_select[1:0] equal to the current state re-enters that state and restarts the divider.
REQ-014 CLEAR: count<=0 on its first cycle, then IDLE on the next edge unless key_en=1.
REQ-015 Divider: 26-bit; cleared to 0 on every key_en and in IDLE/CLEAR; in UP/DOWN increments each cycle and returns to 0 after CNT_MAX.
REQ-016 tick=1 for exactly one cycle in the cycle after the divider equals CNT_MAX in UP or DOWN; a step occurs every CNT_MAX+1 cycles.
REQ-017 The count update is registered in the same edge as tick: count changes in the cycle tick is high.
REQ-018 UP step: count+1; at count=CNT_TOP the next value is 0 and wrap=1 for that cycle.
REQ-019 DOWN step: count-1; at count=0 the next value is CNT_TOP and wrap=1 for that cycle.
REQ-020 Arithmetic is unsigned 8-bit and count never exceeds CNT_TOP; CNT_TOP=255 is legal and wraps naturally.
REQ-021 Simultaneous key_en and divider terminal: key_en wins, no tick, no step, count unchanged (except entry into CLEAR).
REQ-022 IDLE: count held, tick=0, wrap=0.
REQ-023 Within UP/DOWN, wrap is asserted only together with tick.

Reset
REQ-024 sys_rst=1 forces immediately (asynchronously) count=0, mode=IDLE, divider=0, tick=0, wrap=0.
REQ-025 Reset asserted mid-count or mid-CLEAR aborts the operation; after release the block stays in IDLE until the next key_en.
REQ-026 The first key_en accepted after release behaves per REQ-012 with no extra latency.

Verification (CNT_MAX=3, CNT_TOP=9)
REQ-027 Release reset, key_en with key_select=0001 -> mode=01; tick every 4 cycles; count 0,1,2…
REQ-028 UP at count=9, next tick -> count=0 and wrap=1 in the same cycle.
REQ-029 key_select=0010 at count=2 -> DOWN; ticks give 1,0,9; wrap=1 on the 0->9 step.
REQ-030 key_en (0011) in the same cycle as the divider terminal at count=5 -> no tick; count=0 next cycle; mode 11 then 00; count held at 0.
REQ-031 sys_rst pulse mid-UP at count=7 -> count=0, mode=00 immediately; no ticks until a new key_en.
REQ-032 key_en with key_select=1101 while in UP -> treated as UP (01); divider restarts and the next tick arrives 4 cycles later.
